// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache: IDLE/LOOKUP/FILL controller over data and tag CacheMem arrays.
// Optional hit/miss statistics counters are built when RV_CACHE_STATS_EN is defined.

module CacheMem #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          i_clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Synchronous read, write-first on address collision.
  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

module icache_controller #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 5,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ready,
  output logic                  o_busy,
  input  logic                  i_invalidate,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ack,
  output logic [31:0]           o_hits,
  output logic [31:0]           o_misses
);
  localparam int BW        = $clog2(DATA_WIDTH/8);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - BW;
  localparam int WA_WIDTH  = ADDR_WIDTH - BW;
  localparam int LINES     = 2**INDEX_WIDTH;
  localparam int DA_WIDTH  = INDEX_WIDTH + OFFSET_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL} state_t;

  state_t                  r_state, w_next;
  logic [WA_WIDTH-1:0]     r_word;
  logic [OFFSET_WIDTH-1:0] r_cnt;
  logic [LINES-1:0]        r_valid;

  logic [TAG_WIDTH-1:0]    w_tag, w_tag_rdata;
  logic [INDEX_WIDTH-1:0]  w_idx;
  logic [DA_WIDTH-1:0]     w_da_raddr;
  logic [INDEX_WIDTH-1:0]  w_ta_raddr;
  logic                    w_accept, w_hit, w_last, w_fill_we;
  logic                    w_unused;

  assign w_tag    = r_word[WA_WIDTH-1 -: TAG_WIDTH];
  assign w_idx    = r_word[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_accept = (r_state == S_IDLE) && !i_invalidate && i_rd;
  assign w_hit    = r_valid[w_idx] && (w_tag_rdata == w_tag);
  assign w_fill_we = (r_state == S_FILL) && i_mem_ack;
  assign w_last   = w_fill_we && (r_cnt == '1);
  assign w_unused = ^i_addr[BW-1:0];

  // In IDLE the arrays look up the incoming address so data is ready in LOOKUP;
  // otherwise they track the latched request, which makes the post-fill re-lookup hit.
  assign w_da_raddr = (r_state == S_IDLE) ? i_addr[BW +: DA_WIDTH] : r_word[DA_WIDTH-1:0];
  assign w_ta_raddr = (r_state == S_IDLE) ? i_addr[BW+OFFSET_WIDTH +: INDEX_WIDTH] : w_idx;

  CacheMem #(.AW(DA_WIDTH), .DW(DATA_WIDTH)) u_data (
    .i_clock (i_clock),
    .i_we    (w_fill_we),
    .i_waddr ({w_idx, r_cnt}),
    .i_wdata (i_mem_rdata),
    .i_raddr (w_da_raddr),
    .o_rdata (o_rdata)
  );

  CacheMem #(.AW(INDEX_WIDTH), .DW(TAG_WIDTH)) u_tag (
    .i_clock (i_clock),
    .i_we    (w_last),
    .i_waddr (w_idx),
    .i_wdata (w_tag),
    .i_raddr (w_ta_raddr),
    .o_rdata (w_tag_rdata)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: w_next = w_hit ? S_IDLE : S_FILL;
      S_FILL:   if (w_last) w_next = S_LOOKUP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_word  <= '0;
      r_cnt   <= '0;
      r_valid <= '0;
    end else begin
      if (w_accept) r_word <= i_addr[ADDR_WIDTH-1:BW];
      if ((r_state == S_IDLE) && i_invalidate) r_valid <= '0;
      if (r_state == S_LOOKUP) r_cnt <= '0;
      else if (w_fill_we) r_cnt <= r_cnt + 1'b1;
      if (w_last) r_valid[w_idx] <= 1'b1;
    end
  end

  assign o_ready    = (r_state == S_LOOKUP) && w_hit;
  assign o_busy     = (r_state != S_IDLE);
  assign o_mem_rd   = (r_state == S_FILL);
  assign o_mem_addr = o_mem_rd ? {w_tag, w_idx, r_cnt, {BW{1'b0}}} : '0;

`ifdef RV_CACHE_STATS_EN
  logic        r_refill;
  logic [31:0] r_hits, r_misses;

  // r_refill marks the lookup that follows a fill so it is not counted again.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_refill <= 1'b0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (w_last) r_refill <= 1'b1;
      else if (r_state == S_LOOKUP) r_refill <= 1'b0;
      if ((r_state == S_LOOKUP) && w_hit && !r_refill && (r_hits != '1))
        r_hits <= r_hits + 32'd1;
      if ((r_state == S_LOOKUP) && !w_hit && !r_refill && (r_misses != '1))
        r_misses <= r_misses + 32'd1;
    end
  end

  assign o_hits   = r_hits;
  assign o_misses = r_misses;
`else
  assign o_hits   = '0;
  assign o_misses = '0;
`endif
endmodule

// File: tb/tb_icache_controller.sv
// Directed + randomized bench for icache_controller against a line-level cache model and a memory responder.

module tb_icache_controller;
  logic        i_clock = 1'b0;
  logic        i_reset, i_rd, i_invalidate, i_mem_ack;
  logic [31:0] i_addr, i_mem_rdata;
  logic [31:0] o_rdata, o_mem_addr, o_hits, o_misses;
  logic        o_ready, o_busy, o_mem_rd;

  icache_controller dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_addr(i_addr), .i_rd(i_rd),
    .o_rdata(o_rdata), .o_ready(o_ready), .o_busy(o_busy),
    .i_invalidate(i_invalidate), .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_hits(o_hits), .o_misses(o_misses)
  );

  always #5 i_clock = ~i_clock;

  int n_cmp = 0, n_fail = 0;
  int waits = 0, n_acks = 0, stab_err = 0;
  logic [31:0] addr_q [$];

  logic        m_valid [32];
  logic [22:0] m_tag   [32];
  int          m_hits = 0, m_misses = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic chk_stats();
`ifdef RV_CACHE_STATS_EN
    chk("hits", 64'(o_hits), 64'(m_hits));
    chk("misses", 64'(o_misses), 64'(m_misses));
`else
    chk("hits", 64'(o_hits), 64'd0);
    chk("misses", 64'(o_misses), 64'd0);
`endif
  endtask

  // Memory model: acks after 'waits' idle cycles, data derived from the word address.
  initial begin
    logic        prev_rd, prev_ack;
    logic [31:0] prev_addr;
    int          wcnt;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    prev_rd = 1'b0; prev_ack = 1'b0; prev_addr = '0; wcnt = 0;
    forever begin
      @(negedge i_clock);
      if (o_mem_rd) begin
        if (prev_rd && !prev_ack && (o_mem_addr != prev_addr)) stab_err++;
        if (wcnt >= waits) begin
          i_mem_ack = 1'b1; i_mem_rdata = mem_fn(o_mem_addr);
          addr_q.push_back(o_mem_addr); n_acks++; wcnt = 0;
        end else begin
          i_mem_ack = 1'b0; i_mem_rdata = $urandom; wcnt++;
        end
        prev_rd = 1'b1; prev_ack = i_mem_ack; prev_addr = o_mem_addr;
      end else begin
        i_mem_ack = 1'b0; wcnt = 0; prev_rd = 1'b0;
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input int w);
    int          lat, idx;
    logic        hit;
    logic [22:0] tg;
    logic [31:0] base;
    idx = int'(a[8:4]); tg = a[31:9];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    base = {a[31:4], 4'h0};
    waits = w;
    @(negedge i_clock);
    addr_q.delete();
    i_addr = a; i_rd = 1'b1;
    @(posedge i_clock); #1;
    lat = 0;
    while (!o_ready && lat < 400) begin
      @(posedge i_clock); #1; lat++;
    end
    chk("latency", 64'(lat), hit ? 64'd0 : 64'(1 + 4*(w+1)));
    chk("rdata", 64'(o_rdata), 64'(mem_fn({a[31:2], 2'b00})));
    @(negedge i_clock);
    i_rd = 1'b0;
    chk("fill_len", 64'(addr_q.size()), hit ? 64'd0 : 64'd4);
    for (int k = 0; k < addr_q.size() && k < 4; k++)
      chk("fill_addr", 64'(addr_q[k]), 64'(base + 32'(4*k)));
    if (hit) m_hits++;
    else begin
      m_misses++; m_valid[idx] = 1'b1; m_tag[idx] = tg;
    end
    @(posedge i_clock); #1;
    chk_stats();
  endtask

  task automatic inv_pulse(input logic with_rd, input logic [31:0] a);
    @(negedge i_clock);
    i_invalidate = 1'b1; i_rd = with_rd; i_addr = a;
    @(posedge i_clock); #1;
    chk("inv_busy", 64'(o_busy), 64'd0);
    chk("inv_ready", 64'(o_ready), 64'd0);
    @(negedge i_clock);
    i_invalidate = 1'b0; i_rd = 1'b0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base_acks, tries;
    logic [22:0] tg;
    logic [31:0] a;
    i_reset = 1'b0; i_rd = 1'b0; i_invalidate = 1'b0; i_addr = '0;
    model_clear();
    #2;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_mem_rd", 64'(o_mem_rd), 64'd0);
    chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    chk("rst_hits", 64'(o_hits), 64'd0);
    chk("rst_misses", 64'(o_misses), 64'd0);
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;

    do_read(32'h0000_0100, 0);   // cold miss
    do_read(32'h0000_0108, 0);   // hit
    do_read(32'h0000_0300, 0);   // conflict
    do_read(32'h0000_0100, 0);
    inv_pulse(1'b1, 32'h0000_0100);
    do_read(32'h0000_0100, 3);   // refill with wait states

    // Reset in the middle of a fill.
    inv_pulse(1'b0, 32'h0);
    waits = 0; base_acks = n_acks;
    @(negedge i_clock);
    i_addr = 32'h0000_0100; i_rd = 1'b1;
    tries = 0;
    while (n_acks < base_acks + 2 && tries < 50) begin
      @(posedge i_clock); tries++;
    end
    chk("midfill_acks", 64'(n_acks - base_acks), 64'd2);
    #1;
    i_reset = 1'b0; i_rd = 1'b0;
    #1;
    chk("midrst_mem_rd", 64'(o_mem_rd), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_mem_addr", 64'(o_mem_addr), 64'd0);
    model_clear(); m_hits = 0; m_misses = 0;
    chk_stats();
    @(negedge i_clock);
    i_reset = 1'b1;
    do_read(32'h0000_0100, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: tg = 23'h0;
        1: tg = 23'h1;
        2: tg = 23'h2AAAAA;
        default: tg = 23'h7FFFFF;
      endcase
      a = {tg, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) inv_pulse(1'($urandom_range(0, 1)), a);
      do_read(a, $urandom_range(0, 2));
    end

    chk("addr_stable", 64'(stab_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
